deinterleaver: RTL and testbench
================================

// Module: deinterleaver
//
// PURPOSE
//   802.11a receive-side block deinterleaver for one QPSK OFDM symbol
//   (N_CBPS=96, N_BPSC=2, s=1). Sits between the QPSK demapper and the
//   Viterbi decoder. It collects 48 two-bit demapper outputs (96 coded bits)
//   and undoes the transmit interleaver permutation. It then presents the
//   96 restored bits in parallel with a one-cycle ready strobe.
//
// PARAMETERS
//   N_CBPS  96  coded bits per OFDM symbol (fixed; only 96 is supported)
//   N_COL   16  interleaver column count (fixed by 802.11a)
//
// PORTS
//   Clk       in   1   system clock; all state updates on rising edge
//   rst_n     in   1   synchronous active-low reset, sampled on rising Clk
//   en        in   1   in_data valid this cycle; one bit pair is captured per enabled edge
//   in_data   in   2   demapper bit pair; [0] = earlier bit, [1] = later bit
//   out_data  out  96  deinterleaved symbol; bit k = original coded bit k
//   ready     out  1   one-cycle strobe: out_data just updated with a complete symbol
//
// BEHAVIOUR
//   - Reset (rst_n=0 at a rising edge): pair counter=0, capture buffer=0,
//     out_data=96'b0, ready=0. Reset takes priority over en, and a partially
//     collected symbol is discarded.
//   - Capture: on each rising edge with en=1, let n = pair counter (0..47).
//     buffer[2n] <= in_data[0] and buffer[2n+1] <= in_data[1]. Buffer index i
//     is the interleaved (received) bit position.
//   - en=0: counter, buffer, out_data hold; ready=0.
//   - Permutation (deinterleave, s=1 so the second permutation is identity):
//     out_data[16*(i mod 6) + floor(i/6)] = buffer[i], for i = 0..95.
//     Equivalently, out_data[k] = buffer[6*(k mod 16) + floor(k/16)].
//     The mapping is pure wiring, with no arithmetic in the datapath.
//   - Completion: on the edge that captures pair n=47, out_data is loaded with
//     the permutation of the complete buffer, including the pair captured on
//     this same edge. The permuted value is formed combinationally from the
//     stored 94 bits plus the current in_data. On that edge ready <= 1 and the
//     counter wraps to 0.
//   - Latency: out_data and ready are valid in the cycle after the 48th
//     enabled edge, with zero extra pipeline stages.
//   - ready is high for exactly one cycle per symbol. It is 0 on every other
//     edge, including enabled edges with n<47.
//   - out_data holds its value until the next symbol completes or reset
//     occurs; it does not change during collection of the following symbol.
//   - Back-to-back symbols: en may stay high continuously. Pair 0 of the next
//     symbol is captured on the edge immediately after completion, so there
//     are no bubble cycles.
//   - Gaps in en within a symbol are allowed; the count only advances on
//     enabled edges.
//
// TESTING
//   1. rst_n=0 for 2 edges -> out_data=0, ready=0. Release and drive en=0 for
//      10 edges -> ready stays 0.
//   2. en=1 with in_data=2'b10 on pair 0 and 2'b00 on pairs 1..47 -> ready=1
//      after the 48th edge. The only set bit is out_data[16].
//   3. Single 1 at interleaved bit i=6 (pair 3, in_data[0]) -> out_data[1]=1.
//      For i=90 -> out_data[15]. For i=95 -> out_data[95]. All other bits 0.
//   4. Random 96-bit vector generated by the 802.11a QPSK interleaver and fed
//      in order -> out_data equals the original pre-interleave vector. Repeat
//      back-to-back for 3 symbols with continuous en: ready pulses exactly
//      every 48 edges.
//   5. Toggle en every other cycle during a symbol -> completion occurs after
//      the 48th enabled edge (96 clocks), with the same out_data as case 4.
//   6. Assert rst_n=0 after 20 pairs, then send a full symbol -> ready only
//      after 48 new pairs. The result contains no residue from the aborted
//      symbol.

Source files
------------

// File: rtl/deinterleaver.sv
// 802.11a QPSK block deinterleaver: collects 48 bit pairs (96 coded bits) and
// presents the de-permuted symbol in parallel with a one-cycle ready strobe.
module deinterleaver (
    input  logic        Clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  in_data,
    output logic [95:0] out_data,
    output logic        ready
);

    localparam int N_CBPS = 96;
    localparam int N_COL  = 16;
    localparam int N_ROW  = N_CBPS / N_COL;
    localparam logic [5:0] LAST_PAIR = 6'd47;

    logic [5:0]        cnt_q, cnt_d;
    logic [N_CBPS-1:0] buf_q, buf_d;
    logic [N_CBPS-1:0] out_q, out_d;
    logic              rdy_q, rdy_d;

    logic              last_pair;
    logic [N_CBPS-1:0] full_buf;
    logic [N_CBPS-1:0] perm;

    assign last_pair = (cnt_q == LAST_PAIR);

    // Final pair bypasses the buffer so the symbol completes on its own edge.
    assign full_buf = {in_data, buf_q[N_CBPS-3:0]};

    // Received position 6*(k mod 16) + k/16 carries original coded bit k.
    for (genvar k = 0; k < N_CBPS; k++) begin : g_perm
        assign perm[k] = full_buf[N_ROW * (k % N_COL) + k / N_COL];
    end

    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        out_d = out_q;
        rdy_d = 1'b0;
        if (en) begin
            buf_d[{cnt_q, 1'b0} +: 2] = in_data;
            if (last_pair) begin
                cnt_d = '0;
                out_d = perm;
                rdy_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            buf_q <= '0;
            out_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
            out_q <= out_d;
            rdy_q <= rdy_d;
        end
    end

    assign out_data = out_q;
    assign ready    = rdy_q;

endmodule

// File: tb/tb_deinterleaver.sv
// Bench for deinterleaver: single-bit table vectors, interleaved random symbols,
// gapped enable and mid-symbol reset, checked against a queue of expected symbols.
module tb_deinterleaver;

    logic        Clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  in_data;
    logic [95:0] out_data;
    logic        ready;

    deinterleaver dut (
        .Clk      (Clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_data  (in_data),
        .out_data (out_data),
        .ready    (ready)
    );

    always #5 Clk = ~Clk;

    int          total = 0;
    int          bad   = 0;
    logic [95:0] exp_q[$];
    logic [95:0] exp_out = '0;
    int          m_cnt = 0;
    logic        m_rdy = 1'b0;
    logic        m_rst = 1'b0;
    logic        chk_on = 1'b0;

    typedef struct {
        int ibit;   // interleaved (received) bit position carrying the single 1
        int obit;   // output bit expected to be set
    } vec_t;
    vec_t tbl[6];

    // Transmit-side 802.11a QPSK interleaver: coded bit k lands at 6*(k%16)+k/16.
    function automatic logic [95:0] interleave(input logic [95:0] o);
        logic [95:0] r;
        r = '0;
        for (int k = 0; k < 96; k++) r[6 * (k % 16) + k / 16] = o[k];
        return r;
    endfunction

    // Reference timing: which edges should complete a symbol.
    always @(posedge Clk) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_rdy  = 1'b0;
            m_rst  = 1'b1;
            chk_on = 1'b1;
        end else begin
            m_rst = 1'b0;
            m_rdy = en && (m_cnt == 47);
            if (en) m_cnt = (m_cnt == 47) ? 0 : m_cnt + 1;
        end
    end

    always @(negedge Clk) begin
        if (chk_on) begin
            if (m_rst) begin
                exp_out = '0;
            end else if (m_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: ready expected but no symbol queued at %0t", $time);
                end else begin
                    exp_out = exp_q.pop_front();
                end
            end
            total++;
            if (ready !== m_rdy) begin
                bad++;
                $display("FAIL ready at %0t: got %b want %b", $time, ready, m_rdy);
            end
            total++;
            if (out_data !== exp_out) begin
                bad++;
                $display("FAIL out_data at %0t: got %h want %h", $time, out_data, exp_out);
            end
        end
    end

    // Feed npairs pairs of iv; the expected symbol is queued with the 48th pair.
    task automatic send_sym(input logic [95:0] iv, input logic [95:0] ev,
                            input int npairs, input bit gap);
        for (int p = 0; p < npairs; p++) begin
            if (p == 47) exp_q.push_back(ev);
            en      = 1'b1;
            in_data = iv[2 * p +: 2];
            @(posedge Clk); #1;
            if (gap) begin
                en      = 1'b0;
                in_data = 2'($urandom_range(3));
                @(posedge Clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        logic [95:0] iv, ev, orig;

        tbl[0] = '{ibit: 1,  obit: 16};
        tbl[1] = '{ibit: 6,  obit: 1};
        tbl[2] = '{ibit: 90, obit: 15};
        tbl[3] = '{ibit: 95, obit: 95};
        tbl[4] = '{ibit: 0,  obit: 0};
        tbl[5] = '{ibit: 47, obit: 87};

        rst_n   = 1'b0;
        en      = 1'b0;
        in_data = 2'b00;
        repeat (2) @(posedge Clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // Single set bit per symbol: received position vs restored position.
        for (int t = 0; t < 6; t++) begin
            iv = '0;
            ev = '0;
            iv[tbl[t].ibit] = 1'b1;
            ev[tbl[t].obit] = 1'b1;
            send_sym(iv, ev, 48, 1'b0);
            idle(3);
        end

        // Three back-to-back random symbols with en held high.
        for (int s = 0; s < 3; s++) begin
            orig = {$urandom(), $urandom(), $urandom()};
            send_sym(interleave(orig), orig, 48, 1'b0);
        end
        idle(5);

        // en toggled every other cycle: completion after 96 clocks.
        orig = {$urandom(), $urandom(), $urandom()};
        send_sym(interleave(orig), orig, 48, 1'b1);
        idle(5);

        // Abort after 20 pairs of junk, then a clean symbol.
        iv = {$urandom(), $urandom(), $urandom()} | 96'h1;
        send_sym(iv, '0, 20, 1'b0);
        rst_n = 1'b0;
        en    = 1'b1;
        in_data = 2'b11;
        @(posedge Clk); #1;
        rst_n = 1'b1;
        idle(3);
        orig = {$urandom(), $urandom(), $urandom()};
        send_sym(interleave(orig), orig, 48, 1'b0);
        idle(5);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d queued symbols want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
